da_playback: RTL and testbench
==============================

# da_playback

Waveform playback transmitter for the oscilloscope/signal board. It is the output-direction counterpart of the ADC capture path. Stored 8-bit samples are loaded through a simple write port into an internal buffer, then replayed to an external parallel DAC at a programmable rate, either once or looping. A data-valid strobe, `da_clk`, is generated for the DAC. It sits beside the sampling/storage blocks in the top level and drives the DA pins.

## Interface
- `DEPTH_LOG2`, 8: buffer depth = 2^DEPTH_LOG2 samples.
- `DATA_W`, 8: sample / DAC width.
- `DIV_W`, 16: width of the rate divider.
- `MID`, 8'h80: DAC mid-scale value, driven at reset.

Ports:
- `clk` in 1: system clock. Every register is clocked here.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: write one sample to the buffer.
- `wr_data` in DATA_W: sample to write.
- `wr_clr` in 1: empty the buffer.
- `play_start` in 1: start-playback request (level, sampled per cycle).
- `play_stop` in 1: abort playback.
- `loop_mode` in 1: 1 = restart from sample 0 after the last sample.
- `rate_div` in DIV_W: playback period minus one, in clk cycles.
- `da_data` out DATA_W: registered DAC sample.
- `da_clk` out 1: one-cycle DAC latch strobe.
- `busy` out 1: high while in PLAY or DRAIN.
- `done` out 1: one-cycle pulse at natural end of a non-loop pass.
- `wr_full` out 1: buffer holds 2^DEPTH_LOG2 samples.
- `sample_len` out DEPTH_LOG2+1: number of stored samples.

## Operation
- **Buffer**
  - Register array of 2^DEPTH_LOG2 × DATA_W. Contents are not reset.
  - Write pointer = `sample_len`.
  - `wr_en` writes `wr_data` at index `sample_len`, then `sample_len` increments. This happens only when `busy`=0 and `wr_full`=0; otherwise the write is ignored.
  - `wr_clr` sets `sample_len`=0 and has priority over `wr_en` in the same cycle. It is ignored while `busy`=1.
  - `wr_full` = (`sample_len` == 2^DEPTH_LOG2).
- **Rate**
  - `div_eff` = max(`rate_div`, 1), latched when a start is accepted.
  - The sample period is `div_eff`+1 cycles, so the minimum is 2 cycles.
- **FSM states**
  - IDLE
    - `play_start`=1, `play_stop`=0 and `sample_len`>0: go to PLAY; clear the rate counter and `rptr`; latch `div_eff`.
    - `play_start` with `sample_len`=0: ignored.
  - PLAY
    - The counter increments each cycle. A tick occurs in the cycle where counter == `div_eff`; the counter then returns to 0.
    - On a tick: `da_data`<=mem[`rptr`].
      - If `rptr` == `sample_len`-1 and `loop_mode`=1 (sampled that cycle): `rptr`<=0.
      - If `rptr` == `sample_len`-1 and `loop_mode`=0: go to DRAIN.
      - Otherwise: `rptr`++.
  - DRAIN: unconditionally go to IDLE next edge; `done`=1 for that one cycle.
- **`play_stop`**
  - In PLAY or DRAIN: go to IDLE next edge. No `done`, no `da_data` update; `da_data` holds its last value.
  - `play_stop` beats a tick in the same cycle.
- **Ignored inputs**
  - `play_start` while `busy` is ignored.
  - Changing `rate_div` mid-play has no effect.
  - Clearing `loop_mode` mid-play ends playback after the current pass.
- **`da_clk`**
  - Registered copy of the tick: high for exactly the one cycle after each `da_data` update.
  - Forced low in IDLE when reached via `play_stop` or reset.
  - For a natural end, the final strobe still occurs (during DRAIN→IDLE).

## Timing
- **Reset values:** `da_data`=MID, `da_clk`=0, `busy`=0, `done`=0, `sample_len`=0, `wr_full`=0, state IDLE, counters 0. `rst` acts mid-operation immediately.
- **Start:** accepted at edge E0, so `busy`=1 after E0. The first `da_data` update is at edge E0+`div_eff`+1, with `da_clk` high in the following cycle.
- **Steady state:** updates every `div_eff`+1 cycles.
- **Natural end:** last update at edge U; state DRAIN after U; `da_clk`=1 and `done`=1 in cycle U..U+1. `busy` is low after edge U+1, and a new start is accepted at U+1.
- **Write-to-play:** a sample written at edge W is playable by a start accepted at W+1 or later.

## Test plan
- **Single pass, `rate_div`=3:** load 4 samples 10,20,30,40, pulse start → `da_data` steps 10,20,30,40 every 4 cycles. First update 4 cycles after start. `da_clk` follows each update by 1 cycle. `done` is a single pulse with the last strobe, then `busy`=0.
- **Loop mode:** 3 samples {1,2,3}, `loop_mode`=1, `rate_div`=1 → sequence 1,2,3,1,2,3 at period 2. Drop `loop_mode` mid-pass → stops after the next 3, `done`=1 once.
- **`rate_div`=0:** period 2 (treated as 1). Start with empty buffer → `busy` stays 0, no `da_clk`.
- **Buffer full, DEPTH_LOG2=2:** 5 writes → `sample_len`=4, `wr_full`=1, 5th write ignored. `wr_clr` with simultaneous `wr_en` → `sample_len`=0.
- **Stop/priority:** `play_stop` in the same cycle as a tick → no update, `da_clk` stays 0, no `done`. `wr_en` during play → `sample_len` unchanged.
- **Async reset mid-play:** assert `rst` between clock edges → `da_data`=8'h80, `busy`=0 immediately. After release, a new start plays from sample 0.

Source files
------------

// File: rtl/da_playback.sv
// da_playback: waveform playback transmitter for a parallel DAC.
//
// Samples are loaded through a simple write port into an internal register
// buffer. They are then replayed to the DAC at a programmable rate, either
// once or looping, with a one-cycle strobe that follows each sample update.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   wr_en        write wr_data at index sample_len (only while idle, not full)
//   wr_data      sample to write
//   wr_clr       empty the buffer (only while idle, beats wr_en)
//   play_start   start request (level, sampled every cycle)
//   play_stop    abort playback, beats a same-cycle tick
//   loop_mode    1 = wrap to sample 0 after the last sample
//   rate_div     playback period minus one in clk cycles (0 treated as 1)
//   da_data      registered DAC sample, mid-scale at reset
//   da_clk       one-cycle strobe in the cycle after each da_data update
//   busy         playback (or its drain cycle) in progress
//   done         one-cycle pulse at the natural end of a non-loop pass
//   wr_full      buffer holds 2^DEPTH_LOG2 samples
//   sample_len   number of stored samples
module da_playback #(
  parameter int unsigned       DEPTH_LOG2 = 8,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       DIV_W      = 16,
  parameter logic [DATA_W-1:0] MID        = 8'h80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_clr,
  input  logic                  play_start,
  input  logic                  play_stop,
  input  logic                  loop_mode,
  input  logic [DIV_W-1:0]      rate_div,
  output logic [DATA_W-1:0]     da_data,
  output logic                  da_clk,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_full,
  output logic [DEPTH_LOG2:0]   sample_len
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
  logic [DATA_W-1:0]       da_data_q, da_data_d;
  logic                    da_clk_q, da_clk_d;
  logic [DEPTH_LOG2:0]     len_q, len_d;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;

  logic                    tick;
  logic                    last;
  logic                    full;
  logic [DIV_W-1:0]        div_eff;

  assign full      = (len_q == (DEPTH_LOG2+1)'(DEPTH));
  assign last      = ({1'b0, rptr_q} == (len_q - (DEPTH_LOG2+1)'(1)));
  assign div_eff   = (rate_div == '0) ? DIV_W'(1) : rate_div;
  assign mem_waddr = len_q[DEPTH_LOG2-1:0];

  // Playback FSM and rate counter
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    rptr_d    = rptr_q;
    da_data_d = da_data_q;
    tick      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (play_start && !play_stop && (len_q != '0)) begin
          state_d = ST_PLAY;
          cnt_d   = '0;
          rptr_d  = '0;
          div_d   = div_eff;
        end
      end

      ST_PLAY: begin
        if (play_stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q == div_q) begin
          tick      = 1'b1;
          cnt_d     = '0;
          da_data_d = mem_q[rptr_q];
          if (last) begin
            if (loop_mode) begin
              rptr_d = '0;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            rptr_d = rptr_q + DEPTH_LOG2'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      ST_DRAIN: begin
        state_d = ST_IDLE;
        // An abort landing on the drain cycle suppresses the end pulse.
        done    = !play_stop;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    da_clk_d = tick;
  end

  // Buffer write port: frozen while playback is in progress
  always_comb begin
    len_d  = len_q;
    mem_we = 1'b0;
    if (state_q == ST_IDLE) begin
      if (wr_clr) begin
        len_d = '0;
      end else if (wr_en && !full) begin
        mem_we = 1'b1;
        len_d  = len_q + (DEPTH_LOG2+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_W'(1);
      rptr_q    <= '0;
      da_data_q <= MID;
      da_clk_q  <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      rptr_q    <= rptr_d;
      da_data_q <= da_data_d;
      da_clk_q  <= da_clk_d;
      len_q     <= len_d;
    end
  end

  // Sample storage has no reset; only sample_len defines valid contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= wr_data;
    end
  end

  assign da_data    = da_data_q;
  assign da_clk     = da_clk_q;
  assign busy       = (state_q != ST_IDLE);
  assign wr_full    = full;
  assign sample_len = len_q;

endmodule

// File: tb/tb_da_playback.sv
module tb_da_playback;

  localparam int unsigned DL2   = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_clr = 1'b0;
  logic        play_start = 1'b0;
  logic        play_stop = 1'b0;
  logic        loop_mode = 1'b0;
  logic [15:0] rate_div = '0;
  logic [7:0]  da_data;
  logic        da_clk;
  logic        busy;
  logic        done;
  logic        wr_full;
  logic [2:0]  sample_len;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  da_playback #(
    .DEPTH_LOG2 (DL2),
    .DATA_W     (8),
    .DIV_W      (16),
    .MID        (8'h80)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_clr     (wr_clr),
    .play_start (play_start),
    .play_stop  (play_stop),
    .loop_mode  (loop_mode),
    .rate_div   (rate_div),
    .da_data    (da_data),
    .da_clk     (da_clk),
    .busy       (busy),
    .done       (done),
    .wr_full    (wr_full),
    .sample_len (sample_len)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a pass is a sequence of samples emitted every
  // (div+1) cycles counted from the accepting edge.
  typedef enum {M_IDLE, M_PLAY, M_END} mphase_e;
  mphase_e m_phase = M_IDLE;
  int m_mem [DEPTH];
  int m_len = 0;
  int m_div = 1;
  int m_elapsed = 0;
  int m_pos = 0;
  int m_data = 'h80;
  bit m_clk = 1'b0;
  bit m_was_idle;
  bit m_strobe;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = M_IDLE;
      m_len   = 0;
      m_data  = 'h80;
      m_clk   = 1'b0;
    end else begin
      m_was_idle = (m_phase == M_IDLE);
      m_strobe   = 1'b0;
      case (m_phase)
        M_PLAY: begin
          if (play_stop) begin
            m_phase = M_IDLE;
          end else begin
            m_elapsed++;
            if (m_elapsed % (m_div + 1) == 0) begin
              m_data   = m_mem[m_pos];
              m_strobe = 1'b1;
              if (m_pos == m_len - 1) begin
                if (loop_mode) m_pos = 0;
                else m_phase = M_END;
              end else begin
                m_pos++;
              end
            end
          end
        end
        M_END: m_phase = M_IDLE;
        default: begin
          if (play_start && !play_stop && m_len > 0) begin
            m_phase   = M_PLAY;
            m_div     = (rate_div == 0) ? 1 : int'(rate_div);
            m_elapsed = 0;
            m_pos     = 0;
          end
        end
      endcase
      if (m_was_idle) begin
        if (wr_clr) begin
          m_len = 0;
        end else if (wr_en && m_len < DEPTH) begin
          m_mem[m_len] = int'(wr_data);
          m_len++;
        end
      end
      m_clk = m_strobe;
    end
  end

  // Per-cycle comparison against the model, away from the clock edge
  always @(negedge clk) begin
    #2;
    if (check_en) begin
      chk("da_data", 32'(da_data), m_data);
      chk("da_clk", 32'(da_clk), 32'(m_clk));
      chk("busy", 32'(busy), 32'(m_phase != M_IDLE));
      chk("done", 32'(done), 32'((m_phase == M_END) && !play_stop));
      chk("sample_len", 32'(sample_len), m_len);
      chk("wr_full", 32'(wr_full), 32'(m_len == DEPTH));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cyc(1);
    wr_en   = 1'b0;
  endtask

  task automatic start_pulse();
    play_start = 1'b1;
    cyc(1);
    play_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    check_en = 1'b1;
    #3;
    chk("lit reset da_data", 32'(da_data), 32'h80);
    chk("lit reset busy", 32'(busy), 0);
    chk("lit reset len", 32'(sample_len), 0);

    // Fill to capacity; the fifth write is dropped
    cyc(1);
    wr(8'd10); wr(8'd20); wr(8'd30); wr(8'd40); wr(8'd50);
    #3;
    chk("lit full len", 32'(sample_len), 4);
    chk("lit full flag", 32'(wr_full), 1);

    // Single pass, rate_div=3: updates every 4 cycles, first 4 after start
    cyc(1);
    rate_div  = 16'd3;
    loop_mode = 1'b0;
    start_pulse();                       // j=1
    #3; chk("lit pass busy", 32'(busy), 1);
    cyc(3); #3;                          // j=4
    chk("lit pass pre", 32'(da_data), 32'h80);
    chk("lit pass pre clk", 32'(da_clk), 0);
    cyc(1); #3;                          // j=5
    chk("lit pass first", 32'(da_data), 10);
    chk("lit pass first clk", 32'(da_clk), 1);
    cyc(12); #3;                         // j=17
    chk("lit pass last", 32'(da_data), 40);
    chk("lit pass done", 32'(done), 1);
    chk("lit pass last clk", 32'(da_clk), 1);
    cyc(1); #3;                          // j=18
    chk("lit pass idle", 32'(busy), 0);
    chk("lit pass done off", 32'(done), 0);

    // Clear beats a simultaneous write
    cyc(1);
    wr_clr = 1'b1; wr_en = 1'b1; wr_data = 8'd77;
    cyc(1);
    wr_clr = 1'b0; wr_en = 1'b0;
    #3; chk("lit clr len", 32'(sample_len), 0);

    // Start with an empty buffer is ignored
    cyc(1);
    rate_div = 16'd0;
    play_start = 1'b1;
    cyc(3);
    play_start = 1'b0;
    #3;
    chk("lit empty busy", 32'(busy), 0);
    chk("lit empty clk", 32'(da_clk), 0);

    // rate_div=0 behaves as period 2
    cyc(1);
    wr(8'd1); wr(8'd2); wr(8'd3);
    loop_mode = 1'b0;
    start_pulse();                       // j=1
    cyc(1); #3;                          // j=2
    chk("lit div0 hold", 32'(da_data), 40);
    cyc(1); #3;                          // j=3
    chk("lit div0 first", 32'(da_data), 1);
    cyc(4); #3;                          // j=7
    chk("lit div0 last", 32'(da_data), 3);
    chk("lit div0 done", 32'(done), 1);

    // Loop mode, then drop loop_mode mid-pass
    cyc(2);
    rate_div  = 16'd1;
    loop_mode = 1'b1;
    start_pulse();                       // j=1
    cyc(8); #3;                          // j=9
    chk("lit loop wrap", 32'(da_data), 1);
    cyc(1);                              // j=10
    loop_mode = 1'b0;
    cyc(3); #3;                          // j=13
    chk("lit loop end", 32'(da_data), 3);
    chk("lit loop done", 32'(done), 1);
    cyc(1); #3;
    chk("lit loop idle", 32'(busy), 0);

    // Stop colliding with a tick; write during play ignored
    cyc(1);
    rate_div  = 16'd3;
    loop_mode = 1'b1;
    start_pulse();                       // j=1
    cyc(4); #3;                          // j=5
    chk("lit stop first", 32'(da_data), 1);
    cyc(1);                              // j=6
    wr_en = 1'b1; wr_data = 8'd99;
    cyc(1);                              // j=7
    wr_en = 1'b0;
    #3; chk("lit busy write", 32'(sample_len), 3);
    cyc(1);                              // j=8
    play_stop = 1'b1;
    cyc(1);                              // j=9
    play_stop = 1'b0;
    #3;
    chk("lit stop data", 32'(da_data), 1);
    chk("lit stop clk", 32'(da_clk), 0);
    chk("lit stop busy", 32'(busy), 0);
    chk("lit stop done", 32'(done), 0);

    // Asynchronous reset mid-play
    cyc(1);
    rate_div  = 16'd1;
    loop_mode = 1'b1;
    start_pulse();                       // j=1
    cyc(3);                              // j=4
    #3; rst = 1'b1;
    #1;
    chk("lit arst da_data", 32'(da_data), 32'h80);
    chk("lit arst busy", 32'(busy), 0);
    chk("lit arst clk", 32'(da_clk), 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    wr(8'd7); wr(8'd8);
    loop_mode = 1'b0;
    start_pulse();                       // j=1
    cyc(2); #3;                          // j=3
    chk("lit rerun first", 32'(da_data), 7);
    chk("lit rerun clk", 32'(da_clk), 1);
    cyc(2); #3;                          // j=5
    chk("lit rerun last", 32'(da_data), 8);
    chk("lit rerun done", 32'(done), 1);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
